// File: rtl/matrix_wb_slave.sv
// Pipelined Wishbone B4 responder holding the 8x8 LED frame buffer and scanning it onto the matrix pins.
// Optional define MATRIX_DOUBLE_BUFFER_EN: bus uses a back buffer, the scanner a front buffer swapped at frame end.
module matrix_wb_slave #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int REG_COUNT     = 8,
  parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
  parameter int ROW_CYCLES    = 1024,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0] o_wb_rdata,
  output logic [7:0]               o_row,
  output logic [7:0]               o_red,
  output logic [7:0]               o_grn,
  output logic [7:0]               o_blu,
  output logic                     o_frame_start
);

  localparam int MAX_CYC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]         ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0]         BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [WB_ADDR_WIDTH-1:0] LAST_ROW   = WB_ADDR_WIDTH'(REG_COUNT - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic [WB_DATA_WIDTH-1:0] back_mem [REG_COUNT];
  logic [WB_DATA_WIDTH-1:0] disp_word;
  logic                     req_p0, wr_p0, ack_p1;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [WB_ADDR_WIDTH-1:0] row, row_n;
  logic [7:0]               row_d, red_d, grn_d, blu_d;
  logic                     fs_d;

  assign req_p0     = i_wb_cyc & i_wb_stb;
  assign wr_p0      = req_p0 & i_wb_we;
  assign o_wb_stall = 1'b0;
  // An ack is only presented while the master still holds the cycle open.
  assign o_wb_ack   = ack_p1 & i_wb_cyc;

  // Stage p0 -> p1: bus access, read samples the word before a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_p1     <= 1'b0;
      o_wb_rdata <= '0;
      for (int i = 0; i < REG_COUNT; i++) back_mem[i] <= '0;
    end else begin
      ack_p1 <= req_p0;
      if (req_p0 && !i_wb_we) o_wb_rdata <= back_mem[i_wb_addr];
      if (wr_p0) begin
        for (int b = 0; b < WB_SEL_WIDTH; b++)
          if (i_wb_sel[b]) back_mem[i_wb_addr][8*b +: 8] <= i_wb_wdata[8*b +: 8];
      end
    end
  end

`ifdef MATRIX_DOUBLE_BUFFER_EN
  logic [WB_DATA_WIDTH-1:0] front_mem [REG_COUNT];
  logic                     dirty, swap;

  // Copy only at the very end of the frame, and only while the bus is quiet.
  assign swap = (state == ST_SHOW) && (row == LAST_ROW) && (cnt == ROW_LAST) && dirty && !i_wb_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) front_mem[i] <= '0;
    end else if (swap) begin
      dirty     <= 1'b0;
      front_mem <= back_mem;
    end else if (wr_p0) begin
      dirty <= 1'b1;
    end
  end

  assign disp_word = front_mem[row];
`else
  assign disp_word = back_mem[row];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    row_n   = row;
    case (state)
      ST_BLANK: if (cnt == BLANK_LAST) begin
        state_n = ST_SHOW;
        cnt_n   = '0;
      end
      ST_SHOW: if (cnt == ROW_LAST) begin
        state_n = ST_BLANK;
        cnt_n   = '0;
        row_n   = row + 1'b1;
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // Decoded from the next state so the registered pins line up with the state register.
  always_comb begin
    row_d = '0;
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    fs_d  = 1'b0;
    if (state_n == ST_SHOW) begin
      row_d = 8'd1 << row;
      for (int c = 0; c < 8; c++) begin
        red_d[c] = disp_word[WB_DATA_WIDTH - 2 - 4*c];
        grn_d[c] = disp_word[WB_DATA_WIDTH - 3 - 4*c];
        blu_d[c] = disp_word[WB_DATA_WIDTH - 4 - 4*c];
      end
      fs_d = (state == ST_BLANK) && (row == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_row         <= '0;
      o_red         <= '0;
      o_grn         <= '0;
      o_blu         <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_row         <= row_d;
      o_red         <= red_d;
      o_grn         <= grn_d;
      o_blu         <= blu_d;
      o_frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_matrix_wb_slave.sv
// Bench for matrix_wb_slave: directed and random bus traffic against a frame-time reference model.
module tb_matrix_wb_slave;

  localparam int ROWC   = 64;
  localparam int BLANKC = 16;
  localparam int PERIOD = ROWC + BLANKC;
  localparam int FRAME  = 8 * PERIOD;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [2:0]  i_wb_addr;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_wdata;
  logic        o_wb_ack, o_wb_stall, o_frame_start;
  logic [31:0] o_wb_rdata;
  logic [7:0]  o_row, o_red, o_grn, o_blu;

  matrix_wb_slave #(
    .WB_DATA_WIDTH(32), .REG_COUNT(8), .ROW_CYCLES(ROWC), .BLANK_CYCLES(BLANKC)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_sel(i_wb_sel), .i_wb_wdata(i_wb_wdata),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_rdata(o_wb_rdata),
    .o_row(o_row), .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bus-visible words, displayed words, elapsed clocks since reset.
  logic [31:0] mem_m   [8];
  logic [31:0] front_m [8];
  logic [31:0] disp_m  [8];
  bit          dirty_m;
  bit          ack_pend_m;
  logic [31:0] rdata_m;
  int          t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] colour(input logic [31:0] w, input int k);
    logic [7:0] r;
    for (int c = 0; c < 8; c++) r[c] = w[28 - 4*c + k];
    return r;
  endfunction

  task automatic check_outputs(input bit c);
    int  ph, rw;
    bit  show;
    logic [31:0] w;
    ph   = t % PERIOD;
    rw   = (t / PERIOD) % 8;
    show = (ph >= BLANKC);
    w    = disp_m[rw];
    chk("ack",   {31'b0, o_wb_ack},   {31'b0, ack_pend_m && c});
    chk("stall", {31'b0, o_wb_stall}, 32'h0);
    chk("rdata", o_wb_rdata, rdata_m);
    chk("row",   {24'b0, o_row}, show ? (32'h1 << rw) : 32'h0);
    chk("red",   {24'b0, o_red}, show ? {24'b0, colour(w, 2)} : 32'h0);
    chk("grn",   {24'b0, o_grn}, show ? {24'b0, colour(w, 1)} : 32'h0);
    chk("blu",   {24'b0, o_blu}, show ? {24'b0, colour(w, 0)} : 32'h0);
    chk("frame_start", {31'b0, o_frame_start}, {31'b0, show && ph == BLANKC && rw == 0});
  endtask

  task automatic model_edge(input bit c, s, w, input logic [2:0] a,
                            input logic [3:0] sl, input logic [31:0] d);
    bit swap;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_m[i] = '0; front_m[i] = '0; disp_m[i] = '0;
      end
      dirty_m = 0; ack_pend_m = 0; rdata_m = '0; t = 0;
    end else begin
`ifdef MATRIX_DOUBLE_BUFFER_EN
      disp_m = front_m;
      swap = (t % PERIOD == PERIOD - 1) && ((t / PERIOD) % 8 == 7) && dirty_m && !c;
      if (swap) begin
        front_m = mem_m;
        dirty_m = 0;
      end
`else
      swap = 0;
      disp_m = mem_m;
`endif
      ack_pend_m = c && s;
      if (c && s && !w) rdata_m = mem_m[a];
      if (c && s && w) begin
        for (int b = 0; b < 4; b++) if (sl[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
        dirty_m = 1;
      end
      t++;
    end
  endtask

  task automatic step(input bit c, s, w, input logic [2:0] a,
                      input logic [3:0] sl, input logic [31:0] d);
    i_wb_cyc = c; i_wb_stb = s; i_wb_we = w;
    i_wb_addr = a; i_wb_sel = sl; i_wb_wdata = d;
    #1;
    check_outputs(c);
    @(posedge clk);
    model_edge(c, s, w, a, sl, d);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] sl, input logic [31:0] d);
    step(1, 1, 1, a, sl, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1, 1, 0, a, 4'h0, 32'h0);
  endtask

  task automatic run_to(input bit c, input int target);
    while (t < target) step(c, 0, 0, 3'd0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    i_wb_addr = '0; i_wb_sel = '0; i_wb_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_edge(0, 0, 0, 3'd0, 4'h0, 32'h0);
    idle();
    reset = 1'b0;

    // Reset state, blanking, then row 0 shown with a cleared buffer.
    repeat (20) idle();
    chk("row_after_blank", {24'b0, o_row}, 32'h01);
    chk("red_after_blank", {24'b0, o_red}, 32'h0);

    // Single write then readback.
    wr(3'd0, 4'hF, 32'h00666600);
    idle();
    rd(3'd0);
    chk("rd_row0", o_wb_rdata, 32'h00666600);
    idle();

    // Eight back-to-back writes, then view row 0 in the next frame.
    for (int i = 0; i < 8; i++)
      wr(3'(i), 4'hF, (i == 0) ? 32'h05500550 : $urandom);
    idle();
    run_to(0, ((t / FRAME) + 1) * FRAME + BLANKC + 4);
    chk("b2b_row", {24'b0, o_row}, 32'h01);
    chk("b2b_red", {24'b0, o_red}, 32'h66);
    chk("b2b_blu", {24'b0, o_blu}, 32'h66);
    chk("b2b_grn", {24'b0, o_grn}, 32'h00);

    // Partial byte-lane write.
    wr(3'd3, 4'hF, 32'hFFFFFFFF);
    wr(3'd3, 4'b0101, 32'h12345678);
    idle();
    rd(3'd3);
    chk("partial", o_wb_rdata, 32'hFF34FF78);
    idle();

    // Abandoned ack: write still lands.
    wr(3'd5, 4'hF, 32'hA5A5A5A5);
    idle();
    rd(3'd5);
    chk("dropped_wr", o_wb_rdata, 32'hA5A5A5A5);
    idle();

    // Reset with a request in flight: no ack, buffer cleared, scan restarts.
    wr(3'd2, 4'hF, 32'hDEADBEEF);
    reset = 1'b1;
    rd(3'd2);
    reset = 1'b0;
    rd(3'd2);
    chk("after_reset_rd", o_wb_rdata, 32'h0);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
    repeat (3) idle();

`ifdef MATRIX_DOUBLE_BUFFER_EN
    // Swap deferred while the cycle is held open, then taken at the next quiet frame end.
    do_reset();
    wr(3'd0, 4'hF, 32'h44444444);
    run_to(1, FRAME + BLANKC + 4);
    chk("db_deferred_red", {24'b0, o_red}, 32'h00);
    run_to(0, 2 * FRAME + BLANKC);
    chk("db_frame_start", {31'b0, o_frame_start}, 32'h1);
    chk("db_swapped_red", {24'b0, o_red}, 32'hFF);
    repeat (3) idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
